// File: rtl/crop_ctrl.sv
// Crops a rectangular window out of a raster-order pixel stream.
// One configuration is taken in IDLE and applies to exactly one input frame.
module crop_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int MAX_CROP   = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [$clog2(IMG_W):0]  cfg_x0,
    input  logic [$clog2(IMG_W):0]  cfg_w,
    input  logic [$clog2(IMG_H):0]  cfg_y0,
    input  logic [$clog2(IMG_H):0]  cfg_h,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    output logic                    cfg_err,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int XW = $clog2(IMG_W) + 1;
    localparam int YW = $clog2(IMG_H) + 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [XW-1:0]         r_x0, r_w, r_col;
    logic [YW-1:0]         r_y0, r_h, r_row;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid, r_out_last, r_frame_done, r_cfg_err;

    logic                  w_cfg_legal, w_cfg_take, w_cfg_rej, w_cfg_ready;
    logic [XW:0]           w_cfg_xend, w_xend;
    logic [YW:0]           w_cfg_yend, w_yend;
    logic                  w_in_win, w_win_last, w_in_ready, w_in_acc;
    logic                  w_col_end, w_row_end, w_frame_end;

    // One extra bit on every end coordinate so x0+w cannot wrap.
    assign w_cfg_xend  = {1'b0, cfg_x0} + {1'b0, cfg_w};
    assign w_cfg_yend  = {1'b0, cfg_y0} + {1'b0, cfg_h};
    assign w_cfg_legal = (cfg_w != '0) && (cfg_h != '0)
                      && ({1'b0, cfg_w} <= (XW+1)'(MAX_CROP))
                      && ({1'b0, cfg_h} <= (YW+1)'(MAX_CROP))
                      && (w_cfg_xend <= (XW+1)'(IMG_W))
                      && (w_cfg_yend <= (YW+1)'(IMG_H));

    assign w_xend     = {1'b0, r_x0} + {1'b0, r_w};
    assign w_yend     = {1'b0, r_y0} + {1'b0, r_h};
    assign w_in_win   = (r_col >= r_x0) && ({1'b0, r_col} < w_xend)
                     && (r_row >= r_y0) && ({1'b0, r_row} < w_yend);
    assign w_win_last = (({1'b0, r_col} + (XW+1)'(1)) == w_xend)
                     && (({1'b0, r_row} + (YW+1)'(1)) == w_yend);

    // Only in-window pixels can be back-pressured by the output register.
    assign w_in_ready  = (r_state == S_RUN) && (!w_in_win || !r_out_valid || out_ready);
    assign w_in_acc    = in_valid && w_in_ready;
    assign w_col_end   = (r_col == XW'(IMG_W - 1));
    assign w_row_end   = (r_row == YW'(IMG_H - 1));
    assign w_frame_end = w_in_acc && w_col_end && w_row_end;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cfg_ready = 1'b0;
        w_cfg_take  = 1'b0;
        w_cfg_rej   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (w_cfg_legal) begin
                        w_cfg_take  = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_cfg_rej = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_frame_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x0         <= '0;
            r_y0         <= '0;
            r_w          <= '0;
            r_h          <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            r_cfg_err    <= w_cfg_rej;
            if (w_cfg_take) begin
                r_x0  <= cfg_x0;
                r_y0  <= cfg_y0;
                r_w   <= cfg_w;
                r_h   <= cfg_h;
                r_col <= '0;
                r_row <= '0;
            end else if (w_in_acc) begin
                // The last pixel of the frame wraps both counters back to zero.
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + YW'(1);
                end else begin
                    r_col <= r_col + XW'(1);
                end
            end
            if (w_in_acc && w_in_win) begin
                r_out_data  <= in_data;
                r_out_valid <= 1'b1;
                r_out_last  <= w_win_last;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign cfg_ready  = w_cfg_ready;
    assign cfg_err    = r_cfg_err;
    assign in_ready   = w_in_ready;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign busy       = (r_state == S_RUN);
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_crop_ctrl.sv
// Randomized bench for crop_ctrl on an 8x8 frame, checked against a
// window/queue model of the expected cropped stream.
module tb_crop_ctrl;
    localparam int DW = 12;
    localparam int IW = 8;
    localparam int IH = 8;
    localparam int MC = 4;
    localparam int NPIX = IW * IH;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    cfg_x0, cfg_w, cfg_y0, cfg_h;
    logic          cfg_valid, cfg_ready, cfg_err;
    logic [DW-1:0] in_data, out_data;
    logic          in_valid, in_ready, out_valid, out_ready, out_last;
    logic          busy, frame_done;

    always #5 clk = ~clk;

    crop_ctrl #(.DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .MAX_CROP(MC)) dut (
        .clk(clk), .reset(reset),
        .cfg_x0(cfg_x0), .cfg_w(cfg_w), .cfg_y0(cfg_y0), .cfg_h(cfg_h),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .frame_done(frame_done)
    );

    int errs = 0;
    int checks = 0;
    int mx0, my0, mw, mh;
    int expq[$];
    bit run_exp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit inwin(int idx);
        int c = idx % IW;
        int r = idx / IW;
        return (c >= mx0) && (c < mx0 + mw) && (r >= my0) && (r < my0 + mh);
    endfunction

    function automatic bit legal(int x0, int y0, int w, int h);
        return (w >= 1) && (h >= 1) && (w <= MC) && (h <= MC) && (x0 + w <= IW) && (y0 + h <= IH);
    endfunction

    task automatic set_model(int x0, int y0, int w, int h);
        mx0 = x0; my0 = y0; mw = w; mh = h;
        expq.delete();
        for (int i = 0; i < NPIX; i++) if (inwin(i)) expq.push_back(i);
    endtask

    task automatic drive_cfg(int x0, int y0, int w, int h);
        cfg_x0 = 4'(x0); cfg_y0 = 4'(y0); cfg_w = 4'(w); cfg_h = 4'(h);
        cfg_valid = 1'b1;
    endtask

    task automatic apply_cfg(int x0, int y0, int w, int h);
        bit ok = legal(x0, y0, w, h);
        @(negedge clk);
        drive_cfg(x0, y0, w, h);
        in_valid = 1'b0;
        #1;
        chk("cfg_ready_idle", cfg_ready, 1);
        chk("busy_before_cfg", busy, 0);
        chk("in_ready_idle", in_ready, 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("cfg_err", cfg_err, !ok);
        chk("busy_after_cfg", busy, ok);
        if (ok) begin
            set_model(x0, y0, w, h);
            run_exp = 1;
        end else begin
            chk("in_ready_rej", in_ready, 0);
            @(negedge clk);
            chk("cfg_err_pulse", cfg_err, 0);
            chk("busy_rej", busy, 0);
            chk("in_ready_rej2", in_ready, 0);
        end
    endtask

    // mode: 0 ready=1, 1 toggling, 2 random (with random in_valid), 3 stall last pixel
    task automatic run_frame(int mode, int abort_at, bit chain, int nx0, int ny0, int nw, int nh);
        int idx = 0, n_in = 0, n_out = 0, hold = 0, budget = 0, e;
        bit fd_exp = 0, fd_seen = 0, done = 0, pend;
        while (!done) begin
            @(negedge clk);
            budget++;
            cfg_valid = 1'b0;
            chk("frame_done", frame_done, fd_exp);
            chk("busy", busy, run_exp);
            if (fd_exp) begin
                fd_seen = 1;
                if (chain) drive_cfg(nx0, ny0, nw, nh);
            end
            fd_exp = 0;
            in_valid = run_exp && (idx < NPIX) && (mode != 2 || $urandom_range(0, 3) != 0);
            in_data = DW'(idx);
            case (mode)
                1: out_ready = budget[0];
                2: out_ready = ($urandom_range(0, 2) != 0);
                3: begin
                    out_ready = !(out_valid && out_last && hold < 4);
                    if (!out_ready) hold++;
                end
                default: out_ready = 1'b1;
            endcase
            #1;
            pend = (n_in > n_out);
            chk("out_valid", out_valid, pend);
            chk("in_ready", in_ready, run_exp && (!inwin(idx) || !pend || out_ready));
            if (cfg_valid) chk("cfg_ready_b2b", cfg_ready, 1);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("extra_out", 1, 0);
                else begin
                    e = expq.pop_front();
                    chk("out_data", out_data, e);
                    chk("out_last", out_last, expq.size() == 0);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                if (inwin(idx)) n_in++;
                if (idx == NPIX - 1) begin
                    run_exp = 0;
                    fd_exp = 1;
                end
                idx++;
            end
            if (fd_seen && expq.size() == 0) done = 1;
            if (abort_at > 0 && idx == abort_at) done = 1;
            if (budget > 2000) begin
                chk("timeout", 0, 1);
                done = 1;
            end
        end
        if (chain) begin
            set_model(nx0, ny0, nw, nh);
            run_exp = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        run_exp = 0;
    endtask

    initial begin
        int rx0, ry0, rw, rh;
        reset = 1'b1;
        cfg_x0 = '0; cfg_y0 = '0; cfg_w = '0; cfg_h = '0; cfg_valid = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_data", out_data, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        do_reset();

        apply_cfg(0, 0, 5, 2);
        apply_cfg(6, 0, 3, 2);
        apply_cfg(0, 0, 2, 0);
        apply_cfg(15, 0, 2, 2);
        apply_cfg(0, 7, 2, 3);

        apply_cfg(2, 3, 3, 2);
        run_frame(0, 0, 0, 0, 0, 0, 0);
        apply_cfg(2, 3, 3, 2);
        run_frame(1, 0, 0, 0, 0, 0, 0);
        apply_cfg(5, 5, 3, 3);
        run_frame(3, 0, 0, 0, 0, 0, 0);

        apply_cfg(2, 3, 3, 2);
        run_frame(0, 30, 0, 0, 0, 0, 0);
        do_reset();
        apply_cfg(2, 3, 3, 2);
        run_frame(0, 0, 0, 0, 0, 0, 0);

        apply_cfg(2, 3, 3, 2);
        run_frame(0, 0, 1, 1, 1, 4, 4);
        run_frame(2, 0, 0, 0, 0, 0, 0);

        repeat (8) begin
            rx0 = $urandom_range(0, 7); ry0 = $urandom_range(0, 7);
            rw = $urandom_range(0, 5); rh = $urandom_range(0, 5);
            apply_cfg(rx0, ry0, rw, rh);
            if (legal(rx0, ry0, rw, rh)) run_frame(2, 0, 0, 0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/crop_ctrl.md
CROP_CTRL -- requirements
Module: crop_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 12: pixel width in bits.
REQ-002 Parameter IMG_W, default 64: input frame width in pixels.
REQ-003 Parameter IMG_H, default 64: input frame height in pixels.
REQ-004 Parameter MAX_CROP, default 20: largest allowed crop width and height, so the downstream buffer holds one window of 20*20 pixels.
REQ-005 Port clk, input, 1: the only clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Ports cfg_x0 and cfg_w, input, $clog2(IMG_W)+1 each: window left column and window width.
REQ-008 Ports cfg_y0 and cfg_h, input, $clog2(IMG_H)+1 each: window top row and window height.
REQ-009 Port cfg_valid, input, 1: configuration offered. Port cfg_ready, output, 1: configuration accepted.
REQ-010 Port cfg_err, output, 1: one-cycle pulse when an offered configuration is rejected.
REQ-011 Ports in_data, input, DATA_WIDTH; in_valid, input, 1; in_ready, output, 1: raster-order input pixel stream.
REQ-012 Ports out_data, output, DATA_WIDTH; out_valid, output, 1; out_ready, input, 1: cropped pixel stream.
REQ-013 Port out_last, output, 1: marks the final pixel of the window; valid while out_valid=1.
REQ-014 Port busy, output, 1: high in state RUN.
REQ-015 Port frame_done, output, 1: one-cycle pulse at the end of a frame.

Function
REQ-016 The FSM SHALL have two states: IDLE and RUN.
REQ-017 In IDLE: cfg_ready=1 and in_ready=0.
REQ-018 A config is legal when w≥1, h≥1, w≤MAX_CROP, h≤MAX_CROP, x0+w≤IMG_W and y0+h≤IMG_H.
REQ-019 In IDLE with cfg_valid=1 and a legal config: latch x0, y0, w and h, clear col and row, and go to RUN next cycle.
REQ-020 In IDLE with cfg_valid=1 and an illegal config: stay in IDLE and pulse cfg_err for one cycle.
REQ-021 In RUN: cfg_ready=0, and cfg_valid SHALL be ignored.
REQ-022 In RUN, the col counter (0..IMG_W-1) and row counter (0..IMG_H-1) SHALL advance once per accepted input pixel (in_valid && in_ready).
- col wraps to 0 after IMG_W-1, and row then increments.
REQ-023 A pixel is in-window when x0≤col<x0+w and y0≤row<y0+h; the comparison SHALL be done at full width with no overflow.
REQ-024 Out-of-window pixels in RUN: in_ready=1 and the pixel is discarded.
REQ-025 In-window pixels in RUN: in_ready = !out_valid || out_ready.
- On acceptance, out_data is registered with in_data and out_valid is set the next cycle, giving 1-cycle latency.
REQ-026 out_valid SHALL clear on out_valid && out_ready unless a new in-window pixel is accepted in the same cycle.
- out_data and out_valid SHALL be held while out_valid && !out_ready.
REQ-027 out_last SHALL be registered as 1 with the pixel at col=x0+w-1, row=y0+h-1.
REQ-028 When the pixel at col=IMG_W-1, row=IMG_H-1 is accepted: go to IDLE next cycle, pulse frame_done for one cycle, and clear col and row.
REQ-029 A pending output pixel SHALL remain valid across the RUN→IDLE transition until it is accepted.
REQ-030 Exactly w*h pixels SHALL be emitted per frame, in raster order.

Reset
REQ-031 On reset: state=IDLE, col=0, row=0, x0=y0=w=h=0, out_data=0, out_valid=0, out_last=0, frame_done=0, cfg_err=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame within one cycle: the pending output is dropped and no frame_done is produced.

Verification (IMG_W=8, IMG_H=8, MAX_CROP=4)
REQ-033 Config x0=2, y0=3, w=3, h=2, then 64 pixels with value = index and out_ready=1.
- Outputs: 26, 27, 28, 34, 35, 36.
- out_last on 36; frame_done one cycle after pixel 63 is accepted.
REQ-034 Illegal configs (w=5), (x0=6, w=3) and (h=0) -> a cfg_err pulse for each, busy stays 0, and in_ready stays 0.
REQ-035 Same config as REQ-033 with out_ready toggling 1010...
- Output order and values are unchanged, and no pixel is lost or duplicated.
- in_ready=0 only for in-window pixels while the output is stalled.
REQ-036 Window at the corner, x0=5, y0=5, w=3, h=3 -> 9 outputs ending at 63 with out_last=1.
- frame_done follows; stall out_ready=0 on the last pixel and check it stays held while the FSM returns to IDLE.
REQ-037 Assert reset after 30 input pixels -> next cycle busy=0 and out_valid=0.
- A fresh config and full frame then produce the correct 6 outputs.
REQ-038 Two back-to-back frames, with the config applied in the cycle frame_done is high -> the second frame is cropped correctly with no idle gap beyond 1 cycle.
